pcs_rx_seq_ctrl: RTL and testbench
==================================

Name: pcs_rx_seq_ctrl

Overview:
Receive block-sequence controller for the 64b/66b PCS receive path, sitting between dec_lite_rx and xgmii_dec_intf_rx. It classifies each decoded block as C/S/T/D/E and runs the Clause 49 receive state machine with one-block lookahead. Blocks are passed through when the sequence is legal, or replaced by an error block when it is not. It also tracks block lock and hi_ber, and keeps a saturating error-block counter.

Parameters:
IS_40G, 1, 1: 40GBASE-R (start on lane 0 only); 0: 10GBASE-R (start on lane 0 or 4)
DATA_W, 64, decoded block data width
KEEP_W, DATA_W/8, byte keep width
LANE0_CNT_N, IS_40G ? 1 : 2, start_v width
ERR_CNT_W, 8, error counter width

Ports:
clk  in  1  clock
nreset  in  1  asynchronous active-low reset
block_lock_i  in  1  66b block lock from sync
hi_ber_i  in  1  high BER indication
valid_i  in  1  decoded block valid this cycle (gearbox slip cycles low)
ctrl_v_i  in  1  from decoder
idle_v_i  in  1  from decoder
start_v_i  in  LANE0_CNT_N  from decoder
term_v_i  in  1  from decoder
err_v_i  in  1  from decoder
ord_v_i  in  1  from decoder
data_i  in  DATA_W  from decoder
keep_i  in  KEEP_W  from decoder
valid_o  out  1  output block valid
ctrl_v_o, idle_v_o, err_v_o, ord_v_o, term_v_o  out  1 each  to xgmii_dec_intf_rx
start_v_o  out  LANE0_CNT_N  to xgmii_dec_intf_rx
data_o  out  DATA_W  to xgmii_dec_intf_rx
keep_o  out  KEEP_W  to xgmii_dec_intf_rx
state_o  out  3  current rx state encoding
err_cnt_clr_i  in  1  synchronous counter clear
err_cnt_o  out  ERR_CNT_W  saturating RX_E block count

Behaviour:
- Classification, combinational, of the incoming block:
  - D: ctrl_v_i=0.
  - S: ctrl_v_i & |start_v_i & ~term_v_i & ~err_v_i.
  - T: ctrl_v_i & term_v_i & ~|start_v_i & ~err_v_i.
  - C: ctrl_v_i & (idle_v_i|ord_v_i) & ~|start_v_i & ~term_v_i & ~err_v_i.
  - E: anything else, including err_v_i=1 and ctrl_v_i=1 with no flag set.
- Hold register: stores block N (all flags, data, keep, type) plus held_v.
- The decision for block N is made when valid_i brings block N+1; N+1 is the lookahead ("next").
- Output register is updated in that same cycle, so valid_o rises one clk after the valid_i of block N+1. Latency is therefore one valid block plus one cycle.
- valid_i=0: hold and state frozen; valid_o=0 next cycle; outputs keep their last values.
- States: RX_INIT=0, RX_C=1, RX_D=2, RX_T=3, RX_E=4. The state names the classification applied to the emitted block N.
- Transitions, type = type(N), next = type(N+1):
  - RX_INIT, RX_C, RX_T: C->RX_C; S->RX_D; else RX_E.
  - RX_D: D->RX_D; T & next in {S,C}->RX_T; else RX_E.
  - RX_E: C->RX_C; D->RX_D; T & next in {S,C}->RX_T; else RX_E.
- Output in RX_C, RX_D, RX_T: block N passed unchanged.
- Output in RX_E: ctrl_v_o=1, err_v_o=1, all other flags 0, keep_o=0, data_o passes N data (ignored downstream).
- Loss of lock (block_lock_i=0) or hi_ber_i=1: the next clk sets state=RX_INIT, held_v=0, valid_o=0. Any pending block is discarded, not emitted. While either persists, valid_i is ignored.
- On recovery, the first valid block only fills the hold register; the first output comes with the second valid block.
- Reset values: state=RX_INIT, held_v=0, valid_o=0, all flag outputs 0, data_o=0, keep_o=0, err_cnt_o=0.
- err_cnt_o increments by 1 for each emitted RX_E block and saturates at all-ones.
- err_cnt_clr_i has priority over an increment in the same cycle; the result is 0.
- 10G only: start_v_i[1] (start on lane 4) is classified as S. For IS_40G=1 it does not exist.

Decomposition:
- Shared package pcs_rx_pkg: rx_state_e enum (INIT/C/D/T/E, 3 bits), rx_type_e enum (C/S/T/D/E), and the decoded-block struct (flags, data, keep) used by the hold and output registers.
- One sub-module pcs_rx_blk_classify: combinational flags->rx_type_e, instantiated twice (incoming block and hold register) or once with the held type registered.

Test Plan:
1. Reset, lock=1, feed C,S,D,D,T(term_3),C, all valid -> output C,S,D,D,T,C unchanged, valid_o one cycle after each following block; state_o 1,2,2,2,3,1; err_cnt_o=0.
2. S,D,T,D (T followed by D) -> T emitted as error block (ctrl_v_o=1, err_v_o=1, keep_o=0), state_o=4, err_cnt_o=1.
3. C then D without S -> D emitted as error (state RX_E); next C recovers to RX_C.
4. Insert valid_i=0 for 3 cycles mid-frame -> no output, state unchanged; stream resumes identically.
5. Drop block_lock_i mid-frame -> state_o=0 next clk, pending block dropped; relock then C,C -> first output after the second C.
6. Force 300 E blocks with ERR_CNT_W=8 -> err_cnt_o=255. Pulse err_cnt_clr_i in a cycle that also emits an error -> err_cnt_o=0.

Source files
------------

// File: rtl/pcs_rx_seq_ctrl_pkg.sv
// Shared types for the 64b/66b PCS receive sequence controller: rx states,
// block classes, the decoded-block record and the Clause 49 transition function.
package pcs_rx_pkg;

    localparam int BLK_DATA_W  = 64;
    localparam int BLK_KEEP_W  = BLK_DATA_W / 8;
    localparam int START_MAX_W = 2;

    typedef enum logic [2:0] {
        RX_INIT = 3'd0,
        RX_C    = 3'd1,
        RX_D    = 3'd2,
        RX_T    = 3'd3,
        RX_E    = 3'd4
    } rx_state_e;

    typedef enum logic [2:0] {
        TYPE_C = 3'd0,
        TYPE_S = 3'd1,
        TYPE_T = 3'd2,
        TYPE_D = 3'd3,
        TYPE_E = 3'd4
    } rx_type_e;

    typedef struct packed {
        logic                   ctrl_v;
        logic                   idle_v;
        logic [START_MAX_W-1:0] start_v;
        logic                   term_v;
        logic                   err_v;
        logic                   ord_v;
    } blk_flags_t;

    typedef struct packed {
        blk_flags_t              flags;
        logic [BLK_DATA_W-1:0]   data;
        logic [BLK_KEEP_W-1:0]   keep;
    } blk_t;

    // A terminate is only legal when the block after it can open a new
    // sequence (start or control); that is what the lookahead is for.
    function automatic rx_state_e rx_next_state(rx_state_e cur, rx_type_e typ, rx_type_e nxt);
        rx_state_e res;
        logic      t_ok;
        t_ok = (typ == TYPE_T) && ((nxt == TYPE_S) || (nxt == TYPE_C));
        res  = RX_E;
        case (cur)
            RX_D: begin
                if (typ == TYPE_D)  res = RX_D;
                else if (t_ok)      res = RX_T;
            end
            RX_E: begin
                if (typ == TYPE_C)      res = RX_C;
                else if (typ == TYPE_D) res = RX_D;
                else if (t_ok)          res = RX_T;
            end
            default: begin
                if (typ == TYPE_C)      res = RX_C;
                else if (typ == TYPE_S) res = RX_D;
            end
        endcase
        return res;
    endfunction

    function automatic blk_t err_block(blk_t b);
        blk_t r;
        r              = b;
        r.flags        = '0;
        r.flags.ctrl_v = 1'b1;
        r.flags.err_v  = 1'b1;
        r.keep         = '0;
        return r;
    endfunction

endpackage

// File: rtl/pcs_rx_seq_ctrl_if.sv
// Decoded block bus between dec_lite_rx, the sequence controller and
// xgmii_dec_intf_rx. The slave side is the controller.
interface pcs_rx_seq_ctrl_if #(
    parameter int DATA_W      = 64,
    parameter int LANE0_CNT_N = 1
);
    localparam int KEEP_W = DATA_W / 8;

    logic                   valid_i;
    logic                   ctrl_v_i;
    logic                   idle_v_i;
    logic [LANE0_CNT_N-1:0] start_v_i;
    logic                   term_v_i;
    logic                   err_v_i;
    logic                   ord_v_i;
    logic [DATA_W-1:0]      data_i;
    logic [KEEP_W-1:0]      keep_i;

    logic                   valid_o;
    logic                   ctrl_v_o;
    logic                   idle_v_o;
    logic [LANE0_CNT_N-1:0] start_v_o;
    logic                   term_v_o;
    logic                   err_v_o;
    logic                   ord_v_o;
    logic [DATA_W-1:0]      data_o;
    logic [KEEP_W-1:0]      keep_o;

    modport master (
        output valid_i, ctrl_v_i, idle_v_i, start_v_i, term_v_i, err_v_i, ord_v_i, data_i, keep_i,
        input  valid_o, ctrl_v_o, idle_v_o, start_v_o, term_v_o, err_v_o, ord_v_o, data_o, keep_o
    );

    modport slave (
        input  valid_i, ctrl_v_i, idle_v_i, start_v_i, term_v_i, err_v_i, ord_v_i, data_i, keep_i,
        output valid_o, ctrl_v_o, idle_v_o, start_v_o, term_v_o, err_v_o, ord_v_o, data_o, keep_o
    );
endinterface

// File: rtl/pcs_rx_seq_ctrl_classify.sv
// Combinational block classifier: decoder flags -> C/S/T/D/E.
module pcs_rx_blk_classify
    import pcs_rx_pkg::*;
(
    input  blk_flags_t flags_i,
    output rx_type_e   type_o
);
    logic any_start;

    assign any_start = |flags_i.start_v;

    always_comb begin
        type_o = TYPE_E;
        if (!flags_i.ctrl_v)
            type_o = TYPE_D;
        else if (flags_i.err_v)
            type_o = TYPE_E;
        else if (any_start && !flags_i.term_v)
            type_o = TYPE_S;
        else if (flags_i.term_v && !any_start)
            type_o = TYPE_T;
        else if ((flags_i.idle_v || flags_i.ord_v) && !any_start && !flags_i.term_v)
            type_o = TYPE_C;
    end
endmodule

// File: rtl/pcs_rx_seq_ctrl.sv
// Clause 49 receive sequence controller: holds one block, judges it against
// the next valid block and emits it unchanged or as an error block.
module pcs_rx_seq_ctrl
    import pcs_rx_pkg::*;
#(
    parameter int IS_40G      = 1,
    parameter int DATA_W      = BLK_DATA_W,
    parameter int KEEP_W      = DATA_W / 8,
    parameter int LANE0_CNT_N = (IS_40G != 0) ? 1 : 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 block_lock_i,
    input  logic                 hi_ber_i,
    pcs_rx_seq_ctrl_if.slave     bus,
    input  logic                 err_cnt_clr_i,
    output logic [2:0]           state_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);
    rx_state_e             state_q, state_d, step_state;
    logic                  held_v_q, held_v_d;
    blk_t                  held_q, held_d;
    blk_t                  out_q, out_d;
    logic                  valid_o_q, valid_o_d;
    logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

    logic                  lock_ok;
    logic                  emit;
    blk_t                  in_blk;
    rx_type_e              in_type, held_type;
    logic [START_MAX_W-1:0] start_in;
    logic [DATA_W-1:0]     data_in;
    logic [KEEP_W-1:0]     keep_in;

    // 40G only starts on lane 0; the lane-4 start bit is tied off.
    if (IS_40G != 0) begin : g_40g
        assign start_in      = {1'b0, bus.start_v_i[0]};
        assign bus.start_v_o = out_q.flags.start_v[0];
    end else begin : g_10g
        assign start_in      = bus.start_v_i;
        assign bus.start_v_o = out_q.flags.start_v;
    end

    assign data_in = bus.data_i;
    assign keep_in = bus.keep_i;

    always_comb begin
        in_blk.flags.ctrl_v  = bus.ctrl_v_i;
        in_blk.flags.idle_v  = bus.idle_v_i;
        in_blk.flags.start_v = start_in;
        in_blk.flags.term_v  = bus.term_v_i;
        in_blk.flags.err_v   = bus.err_v_i;
        in_blk.flags.ord_v   = bus.ord_v_i;
        in_blk.data          = data_in;
        in_blk.keep          = keep_in;
    end

    pcs_rx_blk_classify u_cls_in   (.flags_i(in_blk.flags), .type_o(in_type));
    pcs_rx_blk_classify u_cls_held (.flags_i(held_q.flags), .type_o(held_type));

    assign lock_ok    = block_lock_i & ~hi_ber_i;
    assign emit       = lock_ok & bus.valid_i & held_v_q;
    assign step_state = rx_next_state(state_q, held_type, in_type);

    always_comb begin
        state_d   = state_q;
        held_v_d  = held_v_q;
        held_d    = held_q;
        out_d     = out_q;
        valid_o_d = 1'b0;
        err_cnt_d = err_cnt_q;

        // Losing lock discards the held block; the stream restarts from fill.
        if (!lock_ok) begin
            state_d  = RX_INIT;
            held_v_d = 1'b0;
        end else if (bus.valid_i) begin
            held_d   = in_blk;
            held_v_d = 1'b1;
            if (held_v_q) begin
                state_d   = step_state;
                valid_o_d = 1'b1;
                out_d     = (step_state == RX_E) ? err_block(held_q) : held_q;
            end
        end

        if (err_cnt_clr_i)
            err_cnt_d = '0;
        else if (emit && (step_state == RX_E) && !(&err_cnt_q))
            err_cnt_d = err_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= RX_INIT;
            held_v_q  <= 1'b0;
            held_q    <= '0;
            out_q     <= '0;
            valid_o_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            held_v_q  <= held_v_d;
            held_q    <= held_d;
            out_q     <= out_d;
            valid_o_q <= valid_o_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.valid_o  = valid_o_q;
    assign bus.ctrl_v_o = out_q.flags.ctrl_v;
    assign bus.idle_v_o = out_q.flags.idle_v;
    assign bus.term_v_o = out_q.flags.term_v;
    assign bus.err_v_o  = out_q.flags.err_v;
    assign bus.ord_v_o  = out_q.flags.ord_v;
    assign bus.data_o   = out_q.data;
    assign bus.keep_o   = out_q.keep;
    assign state_o      = state_q;
    assign err_cnt_o    = err_cnt_q;
endmodule

// File: tb/tb_pcs_rx_seq_ctrl.sv
// Scoreboard bench for pcs_rx_seq_ctrl (40G configuration, 8-bit error counter).
module tb_pcs_rx_seq_ctrl;
    import pcs_rx_pkg::*;

    logic       clk = 1'b0;
    logic       nreset;
    logic       block_lock_i;
    logic       hi_ber_i;
    logic       err_cnt_clr_i;
    logic [2:0] state_o;
    logic [7:0] err_cnt_o;

    always #5 clk = ~clk;

    pcs_rx_seq_ctrl_if #(.DATA_W(64), .LANE0_CNT_N(1)) bus ();

    pcs_rx_seq_ctrl #(
        .IS_40G(1), .DATA_W(64), .KEEP_W(8), .LANE0_CNT_N(1), .ERR_CNT_W(8)
    ) dut (
        .clk(clk), .nreset(nreset), .block_lock_i(block_lock_i), .hi_ber_i(hi_ber_i),
        .bus(bus), .err_cnt_clr_i(err_cnt_clr_i), .state_o(state_o), .err_cnt_o(err_cnt_o)
    );

    typedef struct packed {
        logic ctrl, idle, start, term, err, ord;
        logic [63:0] data;
        logic [7:0]  keep;
    } tblk_t;

    typedef logic [80:0] ovec_t;

    ovec_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    tblk_t prev_blk;
    bit    have_prev = 0;

    function automatic tblk_t mk(logic c, logic i, logic s, logic t, logic e, logic o,
                                 logic [63:0] d, logic [7:0] k);
        tblk_t b;
        b = '{ctrl: c, idle: i, start: s, term: t, err: e, ord: o, data: d, keep: k};
        return b;
    endfunction

    function automatic tblk_t blk_c(logic [63:0] d);  return mk(1,1,0,0,0,0,d,8'h00); endfunction
    function automatic tblk_t blk_s(logic [63:0] d);  return mk(1,0,1,0,0,0,d,8'hfe); endfunction
    function automatic tblk_t blk_d(logic [63:0] d);  return mk(0,0,0,0,0,0,d,8'hff); endfunction
    function automatic tblk_t blk_t3(logic [63:0] d); return mk(1,0,0,1,0,0,d,8'h07); endfunction
    function automatic tblk_t blk_e(logic [63:0] d);  return mk(1,0,0,0,0,0,d,8'h00); endfunction

    // Expected output: pass-through, or the error block form when judged RX_E.
    function automatic ovec_t expv(tblk_t b, logic [2:0] st);
        if (st == 3'd4)
            return {st, 6'b100010, b.data, 8'h00};
        return {st, b.ctrl, b.idle, b.start, b.term, b.err, b.ord, b.data, b.keep};
    endfunction

    always @(negedge clk) begin
        ovec_t obs, e;
        if (nreset && bus.valid_o) begin
            obs = {state_o, bus.ctrl_v_o, bus.idle_v_o, bus.start_v_o, bus.term_v_o,
                   bus.err_v_o, bus.ord_v_o, bus.data_o, bus.keep_o};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL out_unexpected got=%h want=nothing", obs);
            end else begin
                e = exp_q.pop_front();
                if (obs !== e) begin
                    failures++;
                    $display("FAIL out_block got=%h want=%h", obs, e);
                end
            end
        end
    end

    task automatic drive(input tblk_t b);
        bus.valid_i   = 1'b1;
        bus.ctrl_v_i  = b.ctrl;
        bus.idle_v_i  = b.idle;
        bus.start_v_i = b.start;
        bus.term_v_i  = b.term;
        bus.err_v_i   = b.err;
        bus.ord_v_i   = b.ord;
        bus.data_i    = b.data;
        bus.keep_i    = b.keep;
    endtask

    // Presents block b for one cycle; the previously sent block is emitted now
    // with state st_prev.
    task automatic send(input tblk_t b, input logic [2:0] st_prev);
        if (have_prev) exp_q.push_back(expv(prev_blk, st_prev));
        prev_blk  = b;
        have_prev = 1;
        drive(b);
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
    endtask

    task automatic flush();
        block_lock_i  = 1'b0;
        err_cnt_clr_i = 1'b1;
        bus.valid_i   = 1'b0;
        @(posedge clk); #1;
        block_lock_i  = 1'b1;
        err_cnt_clr_i = 1'b0;
        have_prev     = 0;
    endtask

    task automatic check_drained(input string name);
        @(negedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain pending=%0d want=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_cnt(input string name, input logic [7:0] want);
        checks++;
        if (err_cnt_o !== want) begin
            failures++;
            $display("FAIL %s_err_cnt got=%0d want=%0d", name, err_cnt_o, want);
        end
    endtask

    task automatic test_reset();
        nreset = 1'b0; block_lock_i = 1'b1; hi_ber_i = 1'b0; err_cnt_clr_i = 1'b0;
        drive(blk_c(64'h0)); bus.valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 nreset = 1'b1;
        @(negedge clk);
        checks += 3;
        if (state_o !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d want=0", state_o); end
        if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", bus.valid_o); end
        if ({bus.ctrl_v_o, bus.idle_v_o, bus.start_v_o, bus.term_v_o, bus.err_v_o, bus.ord_v_o,
             bus.data_o, bus.keep_o} !== 78'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", bus.data_o);
        end
        check_cnt("reset", 8'd0);
        @(posedge clk); #1;
    endtask

    task automatic test_legal_frame();
        send(blk_c(64'h1111), 3'd0);
        send(blk_s(64'h2222), 3'd1);
        send(blk_d(64'h3333), 3'd2);
        send(blk_d(64'h4444), 3'd2);
        send(blk_t3(64'h5555), 3'd2);
        send(blk_c(64'h6666), 3'd3);
        send(blk_c(64'h7777), 3'd1);
        check_drained("legal");
        check_cnt("legal", 8'd0);
    endtask

    task automatic test_bad_term();
        flush();
        send(blk_s(64'hA1), 3'd0);
        send(blk_d(64'hA2), 3'd2);
        send(blk_t3(64'hA3), 3'd2);
        send(blk_d(64'hA4), 3'd4);
        send(blk_c(64'hA5), 3'd2);
        check_drained("bad_term");
        check_cnt("bad_term", 8'd1);
    endtask

    task automatic test_missing_start();
        flush();
        send(blk_c(64'hB1), 3'd0);
        send(blk_d(64'hB2), 3'd1);
        send(blk_c(64'hB3), 3'd4);
        send(blk_c(64'hB4), 3'd1);
        send(mk(1,0,1,0,1,0,64'hB5,8'hff), 3'd1);
        send(blk_c(64'hB6), 3'd4);
        check_drained("no_start");
        check_cnt("no_start", 8'd2);
    endtask

    task automatic test_bubbles();
        flush();
        send(blk_s(64'hC1), 3'd0);
        send(blk_d(64'hC2), 3'd2);
        @(negedge clk);
        checks++;
        if (bus.valid_o !== 1'b1) begin failures++; $display("FAIL bubble_latency got=%b want=1", bus.valid_o); end
        repeat (3) begin
            @(negedge clk);
            checks += 3;
            if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL bubble_valid got=%b want=0", bus.valid_o); end
            if (state_o !== 3'd2) begin failures++; $display("FAIL bubble_state got=%0d want=2", state_o); end
            if (bus.data_o !== 64'hC1) begin failures++; $display("FAIL bubble_hold got=%h want=c1", bus.data_o); end
        end
        send(blk_d(64'hC3), 3'd2);
        send(blk_t3(64'hC4), 3'd2);
        send(blk_c(64'hC5), 3'd3);
        send(blk_c(64'hC6), 3'd1);
        check_drained("bubble");
    endtask

    task automatic test_lock_loss();
        flush();
        send(blk_c(64'hD1), 3'd0);
        send(blk_s(64'hD2), 3'd1);
        send(blk_d(64'hD3), 3'd2);
        block_lock_i = 1'b0;
        @(posedge clk); #1;
        checks += 2;
        if (state_o !== 3'd0) begin failures++; $display("FAIL unlock_state got=%0d want=0", state_o); end
        if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL unlock_valid got=%b want=0", bus.valid_o); end
        drive(blk_c(64'hDE));
        repeat (2) @(posedge clk);
        #1 block_lock_i = 1'b1; hi_ber_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 bus.valid_i = 1'b0; hi_ber_i = 1'b0;
        checks++;
        if (state_o !== 3'd0) begin failures++; $display("FAIL hi_ber_state got=%0d want=0", state_o); end
        have_prev = 0;
        send(blk_c(64'hD4), 3'd0);
        @(negedge clk);
        checks++;
        if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL relock_fill got=%b want=0", bus.valid_o); end
        send(blk_c(64'hD5), 3'd1);
        @(negedge clk);
        checks++;
        if (bus.valid_o !== 1'b1) begin failures++; $display("FAIL relock_first got=%b want=1", bus.valid_o); end
        check_drained("relock");
    endtask

    task automatic test_err_counter();
        flush();
        for (int i = 0; i <= 300; i++) send(blk_e(64'(i)), 3'd4);
        check_cnt("saturate", 8'd255);
        err_cnt_clr_i = 1'b1;
        send(blk_e(64'hF0), 3'd4);
        err_cnt_clr_i = 1'b0;
        check_cnt("clear_prio", 8'd0);
        send(blk_c(64'hF1), 3'd4);
        check_cnt("after_clear", 8'd1);
        check_drained("err_cnt");
    endtask

    initial begin
        test_reset();
        test_legal_frame();
        test_bad_term();
        test_missing_start();
        test_bubbles();
        test_lock_loss();
        test_err_counter();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
